// File: rtl/y86_execute_stage_p.sv
// ---------------------------------------------------------------------------
// y86_execute_stage_p
//   Y86-64 Execute stage with the condition-code register and the E/M
//   pipeline register. It is parametrised on data width and register-none
//   encoding. An optional shift-add multiplier implements OPq ifun 4 (mulq).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   E_*                   instruction currently in Execute
//   m_stat, W_stat        status of the instructions in Memory / Writeback,
//                         used to suppress CC updates behind an exception
//   M_stall, M_bubble     E/M register control (hold / insert nop)
//   e_valE,e_dstE,e_Cnd   combinational results, forwarded to decode
//   e_busy                multiplier occupying Execute; upstream must stall
//   M_*                   registered outputs to the Memory stage
//   zf, sf, of            condition-code register
// ---------------------------------------------------------------------------
module y86_execute_stage_p #(
  parameter int          W      = 64,
  parameter bit          MUL_EN = 1'b1,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic         e_busy,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  localparam logic [2:0]   SAOK  = 3'd1;
  localparam logic [3:0]   INOP  = 4'h1;
  localparam logic [3:0]   IOPQ  = 4'h6;
  localparam logic [3:0]   ICMOV = 4'h2;
  localparam int           CW    = $clog2(W);
  localparam logic [W-1:0] STEP  = W'(W / 8);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2:0]      m_stat_q, m_stat_d;
  logic [3:0]      m_icode_q, m_icode_d, m_dste_q, m_dste_d, m_dstm_q, m_dstm_d;
  logic            m_cnd_q, m_cnd_d;
  logic [W-1:0]    m_vale_q, m_vale_d, m_vala_q, m_vala_d;
  logic            zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  logic            all_aok, mul_trig, busy_raw, cc_upd, alu_of;
  logic [W-1:0]    step_sum, sum, diff;

  assign all_aok  = (E_stat == SAOK) && (m_stat == SAOK) && (W_stat == SAOK);
  assign mul_trig = MUL_EN && (E_icode == IOPQ) && (E_ifun == 4'h4) && all_aok;
  // One adder serves both the RUN step and the final partial product,
  // which is folded into DONE so the busy window is exactly W cycles.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign sum      = E_valB + E_valA;
  assign diff     = E_valB - E_valA;

  // ALU
  always_comb begin
    e_valE = '0;
    alu_of = 1'b0;
    case (E_icode)
      4'h2:       e_valE = E_valA;
      4'h3:       e_valE = E_valC;
      4'h4, 4'h5: e_valE = E_valB + E_valC;
      4'h8, 4'hA: e_valE = E_valB - STEP;
      4'h9, 4'hB: e_valE = E_valB + STEP;
      4'h6: begin
        case (E_ifun)
          4'h0: begin
            e_valE = sum;
            alu_of = (E_valA[W-1] == E_valB[W-1]) && (sum[W-1] != E_valB[W-1]);
          end
          4'h1: begin
            e_valE = diff;
            alu_of = (E_valA[W-1] != E_valB[W-1]) && (diff[W-1] != E_valB[W-1]);
          end
          4'h2: e_valE = E_valB & E_valA;
          4'h3: e_valE = E_valB ^ E_valA;
          4'h4: begin
            if (!MUL_EN)
              e_valE = E_valB ^ E_valA;
            else if (state_q == S_DONE)
              e_valE = step_sum;
          end
          default: e_valE = '0;
        endcase
      end
      default: e_valE = '0;
    endcase
  end

  // Condition evaluation from the current CC register
  always_comb begin
    case (E_ifun)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = (sf_q ^ of_q) | zf_q;
      4'h2:    e_Cnd = sf_q ^ of_q;
      4'h3:    e_Cnd = zf_q;
      4'h4:    e_Cnd = ~zf_q;
      4'h5:    e_Cnd = ~(sf_q ^ of_q);
      4'h6:    e_Cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == ICMOV) && !e_Cnd) ? RNONE : E_dstE;

  // Multiplier FSM
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_trig) begin
          busy_raw = 1'b1;
          if (!M_bubble) begin
            acc_d    = '0;
            mcand_d  = E_valB;
            mplier_d = E_valA;
            cnt_d    = '0;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy_raw = 1'b1;
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last registered step; bit W-1 of the multiplier is added in DONE.
        if (cnt_q == CW'(W - 2)) state_d = S_DONE;
        if (M_bubble)             state_d = S_IDLE;
      end
      S_DONE: begin
        if (M_bubble || !M_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces the pipeline to a bubble immediately, so busy drops with it.
  assign e_busy = busy_raw & ~rst;

  // Condition codes
  assign cc_upd = (E_icode == IOPQ) && all_aok && !M_stall && !M_bubble && !busy_raw;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_upd) begin
      zf_d = (e_valE == '0);
      sf_d = e_valE[W-1];
      of_d = alu_of;
    end
  end

  // E/M register: bubble > stall > busy bubble > load
  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (M_bubble || (!M_stall && busy_raw)) begin
      m_stat_d  = SAOK;
      m_icode_d = INOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
      m_dstm_d  = RNONE;
    end else if (!M_stall) begin
      m_stat_d  = E_stat;
      m_icode_d = E_icode;
      m_cnd_d   = e_Cnd;
      m_vale_d  = e_valE;
      m_vala_d  = E_valA;
      m_dste_d  = e_dstE;
      m_dstm_d  = E_dstM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      m_stat_q  <= SAOK;
      m_icode_q <= INOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_Cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;
  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;

endmodule
